// File: rtl/pel_feeder.sv
// pel_feeder: streams template-block (TB) then search-window (SW) pixels from a
// pixel memory into the first line of the systolic PE array.
//
// Optional feature: define PEL_FEEDER_TB_REUSE_EN to add the reuse_tb input.
// When reuse_tb is 1 together with an accepted start, the TB phase is skipped.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin one TB+SW transfer (sampled only in IDLE)
//   tb_base, sw_base      base addresses, latched on accepted start
//   sw_stride             SW memory row pitch, latched on accepted start
//   stall                 downstream hold; no read issues while high
//   reuse_tb              (PEL_FEEDER_TB_REUSE_EN only) skip the TB phase
//   mem_rd_en, mem_addr   read strobe/address; mem_rdata valid one cycle later
//   pel_tb/en_tb          TB pixel and one-cycle shift enable
//   pel_sw/en_sw          SW pixel and one-cycle shift enable
//   busy, done            transfer in progress / one-cycle completion pulse
module pel_feeder #(
  parameter int unsigned ARRAY_SIZE = 16,
  parameter int unsigned SW_SIZE    = 24,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] tb_base,
  input  logic [ADDR_W-1:0] sw_base,
  input  logic [ADDR_W-1:0] sw_stride,
  input  logic              stall,
`ifdef PEL_FEEDER_TB_REUSE_EN
  input  logic              reuse_tb,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pel_tb,
  output logic              en_tb,
  output logic [7:0]        pel_sw,
  output logic              en_sw,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TB_N  = ARRAY_SIZE * ARRAY_SIZE;
  localparam int unsigned SW_N  = SW_SIZE * SW_SIZE;
  localparam int unsigned MAX_N = (TB_N > SW_N) ? TB_N : SW_N;
  localparam int unsigned CNT_W = $clog2(MAX_N + 1);
  localparam int unsigned COL_W = $clog2(SW_SIZE + 1);

  typedef enum logic [1:0] {IDLE, TB_RD, SW_RD, DRAIN} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    rd_cnt;
  logic [COL_W-1:0]    sw_col;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   row_base_q;
  logic [ADDR_W-1:0]   stride_q;
  logic                inflight, inflight_sw;
  logic                skid_v, skid_sw;
  logic [7:0]          skid_data;
  logic                rd_issue_c, drain_empty_c, tb_last_c, sw_last_c, reuse_c;

`ifdef PEL_FEEDER_TB_REUSE_EN
  assign reuse_c = reuse_tb;
`else
  assign reuse_c = 1'b0;
`endif

  assign mem_rd_en = rd_issue_c;
  assign mem_addr  = addr_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, read issue, and drain-complete detection
  always_comb begin
    state_nx      = state;
    rd_issue_c    = 1'b0;
    drain_empty_c = 1'b0;
    tb_last_c     = (rd_cnt == CNT_W'(TB_N - 1));
    sw_last_c     = (rd_cnt == CNT_W'(SW_N - 1));
    case (state)
      IDLE: begin
        if (start) state_nx = reuse_c ? SW_RD : TB_RD;
      end
      TB_RD: begin
        rd_issue_c = !stall;
        if (!stall && tb_last_c) state_nx = SW_RD;
      end
      SW_RD: begin
        rd_issue_c = !stall;
        if (!stall && sw_last_c) state_nx = DRAIN;
      end
      DRAIN: begin
        // Nothing in flight or parked: the output register is emitting the last pixel now.
        drain_empty_c = !inflight && !skid_v && !done;
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address generation, read tracking, skid buffer and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt      <= '0;
      sw_col      <= '0;
      addr_q      <= '0;
      row_base_q  <= '0;
      stride_q    <= '0;
      inflight    <= 1'b0;
      inflight_sw <= 1'b0;
      skid_v      <= 1'b0;
      skid_sw     <= 1'b0;
      skid_data   <= '0;
      pel_tb      <= '0;
      pel_sw      <= '0;
      en_tb       <= 1'b0;
      en_sw       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= drain_empty_c;

      if (state == IDLE && start) begin
        // TB is pushed last-pixel-first so pixel (0,0) lands at PE0.
        addr_q     <= reuse_c ? sw_base : tb_base + ADDR_W'(TB_N - 1);
        row_base_q <= sw_base;
        stride_q   <= sw_stride;
        rd_cnt     <= '0;
        sw_col     <= '0;
      end else if (rd_issue_c) begin
        if (state == TB_RD) begin
          if (tb_last_c) begin
            addr_q <= row_base_q;
            rd_cnt <= '0;
          end else begin
            addr_q <= addr_q - ADDR_W'(1);
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end else begin
          rd_cnt <= rd_cnt + CNT_W'(1);
          if (sw_col == COL_W'(SW_SIZE - 1)) begin
            sw_col     <= '0;
            addr_q     <= row_base_q + stride_q;
            row_base_q <= row_base_q + stride_q;
          end else begin
            sw_col <= sw_col + COL_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
      end

      inflight    <= rd_issue_c;
      inflight_sw <= (state == SW_RD);

      // Skid data has priority over returning data; both cannot coexist since
      // no read issues in a stalled cycle.
      en_tb <= 1'b0;
      en_sw <= 1'b0;
      if (!stall) begin
        if (skid_v) begin
          skid_v <= 1'b0;
          if (skid_sw) begin en_sw <= 1'b1; pel_sw <= skid_data; end
          else         begin en_tb <= 1'b1; pel_tb <= skid_data; end
        end else if (inflight) begin
          if (inflight_sw) begin en_sw <= 1'b1; pel_sw <= mem_rdata; end
          else             begin en_tb <= 1'b1; pel_tb <= mem_rdata; end
        end
      end else if (inflight) begin
        skid_v    <= 1'b1;
        skid_sw   <= inflight_sw;
        skid_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pel_feeder.sv
// tb_pel_feeder: randomized and directed bench for pel_feeder (ARRAY_SIZE=4, SW_SIZE=8).
// A queue model holds the expected read addresses and the expected pixel stream.
module tb_pel_feeder;

  localparam int AS   = 4;
  localparam int SS   = 8;
  localparam int TB_N = AS * AS;
  localparam int SW_N = SS * SS;

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic [15:0] tb_base, sw_base, sw_stride;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata, pel_tb, pel_sw;
  logic        en_tb, en_sw, busy, done;
`ifdef PEL_FEEDER_TB_REUSE_EN
  logic        reuse_tb = 1'b0;
`endif

  pel_feeder #(.ARRAY_SIZE(AS), .SW_SIZE(SS), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tb_base(tb_base), .sw_base(sw_base), .sw_stride(sw_stride), .stall(stall),
`ifdef PEL_FEEDER_TB_REUSE_EN
    .reuse_tb(reuse_tb),
`endif
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pel_tb(pel_tb), .en_tb(en_tb), .pel_sw(pel_sw), .en_sw(en_sw),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory: data = addr[7:0], one-cycle latency; garbage when not read.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_addr[7:0] : 8'($urandom);

  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - start_cyc);
    end
  endfunction

  // Reference model state
  logic [15:0] addr_q[$];
  logic [8:0]  pix_q[$];
  int          tb_exp;
  bit          busy_exp = 0, armed = 0, rst_seen = 0;
  logic [7:0]  hold_tb = 0, hold_sw = 0;

  // Per-transfer observations
  int tr_rd, tr_tb, tr_sw, first_rd, last_rd, first_tb, last_tbc, first_sw, last_swc;
  int done_rel, busy_first, busy_last, last_ensw_cyc;
  int rd_total = 0, en_total = 0, done_total = 0;
  logic [7:0]  first_pel_tb, last_pel_tb, first_pel_sw, last_pel_sw;
  logic [15:0] rd_log[0:TB_N+SW_N-1];
  logic [15:0] sw_log[0:SW_N-1];

  function automatic void model_start(input logic [15:0] tbb, swb, str, input bit reuse);
    logic [15:0] a;
    addr_q.delete();
    pix_q.delete();
    tb_exp = reuse ? 0 : TB_N;
    if (!reuse)
      for (int k = TB_N - 1; k >= 0; k--) begin
        a = tbb + 16'(k);
        addr_q.push_back(a);
        pix_q.push_back({1'b0, a[7:0]});
      end
    for (int r = 0; r < SS; r++)
      for (int c = 0; c < SS; c++) begin
        a = swb + 16'(r) * str + 16'(c);
        addr_q.push_back(a);
        pix_q.push_back({1'b1, a[7:0]});
      end
    tr_rd = 0; tr_tb = 0; tr_sw = 0;
    first_rd = -1; last_rd = -1; first_tb = -1; last_tbc = -1; first_sw = -1; last_swc = -1;
    done_rel = -1; busy_first = -1; busy_last = -1;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: checks every cycle, away from the active edge
  always @(negedge clk) begin
    int rel, idx;
    logic [8:0] e;
    bit accept;
    rel = cyc - start_cyc;
    if (armed) begin
      if (rst_seen) begin
        chk("rst_outputs", {busy, done, en_tb, en_sw, mem_rd_en}, 0);
        chk("rst_pels", {pel_tb, pel_sw, mem_addr}, 0);
      end
      chk("busy", busy, busy_exp);
      chk("rd_when_stalled", mem_rd_en & stall, 0);
      chk("en_exclusive", en_tb & en_sw, 0);
      if (mem_rd_en) begin
        rd_total++;
        if (addr_q.size() == 0) chk("extra_read", mem_rd_en, 0);
        else chk("rd_addr", mem_addr, addr_q.pop_front());
        if (tr_rd < TB_N + SW_N) rd_log[tr_rd] = mem_addr;
        idx = tr_rd - tb_exp;
        if (idx >= 0 && idx < SW_N) sw_log[idx] = mem_addr;
        tr_rd++;
        if (first_rd < 0) first_rd = rel;
        last_rd = rel;
      end
      if (en_tb | en_sw) begin
        en_total++;
        if (pix_q.size() == 0) chk("extra_pixel", {en_sw, en_tb}, 0);
        else begin
          e = pix_q.pop_front();
          chk("pix_kind", en_sw, e[8]);
          chk("pix_pel", en_sw ? pel_sw : pel_tb, e[7:0]);
        end
        if (en_tb) begin
          tr_tb++;
          if (first_tb < 0) begin first_tb = rel; first_pel_tb = pel_tb; end
          last_tbc = rel; last_pel_tb = pel_tb;
        end
        if (en_sw) begin
          tr_sw++;
          if (first_sw < 0) begin first_sw = rel; first_pel_sw = pel_sw; end
          last_swc = rel; last_pel_sw = pel_sw; last_ensw_cyc = cyc;
        end
      end
      if (!en_tb) chk("pel_tb_hold", pel_tb, hold_tb); else hold_tb = pel_tb;
      if (!en_sw) chk("pel_sw_hold", pel_sw, hold_sw); else hold_sw = pel_sw;
      if (busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (done) begin
        done_total++;
        done_rel = rel;
        chk("done_after_last_en_sw", cyc, last_ensw_cyc + 1);
        chk("done_left_over", pix_q.size() + addr_q.size(), 0);
      end
    end
    if (rst) begin
      addr_q.delete(); pix_q.delete();
      busy_exp = 0; hold_tb = 0; hold_sw = 0;
      rst_seen = 1; armed = 1;
    end else begin
      rst_seen = 0;
      accept = armed && start && !busy_exp;
      if (done) busy_exp = 0;
      if (accept) begin
`ifdef PEL_FEEDER_TB_REUSE_EN
        model_start(tb_base, sw_base, sw_stride, reuse_tb);
`else
        model_start(tb_base, sw_base, sw_stride, 1'b0);
`endif
        busy_exp = 1;
        start_cyc = cyc;
      end
    end
  end

  // Stall generator: random 50% in mode 1, plus one 10-cycle hold after the last TB read
  int stall_mode = 0, force_n = 0;
  bit forced = 0;
  always @(posedge clk) begin
    #1;
    if (force_n > 0) begin
      stall = 1'b1;
      force_n--;
    end else stall = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (tr_rd == 0) forced = 0;
    if (stall_mode == 1 && tr_rd == TB_N && tb_exp == TB_N && !forced) begin
      force_n = 10;
      forced = 1;
    end
  end

  // Start a transfer in the current cycle and wait (bounded) for done.
  task automatic run_transfer(input logic [15:0] tbb, swb, str, input bit reuse, input bit poke);
    int d0;
    bit got;
    d0 = done_total;
    tb_base = tbb; sw_base = swb; sw_stride = str;
`ifdef PEL_FEEDER_TB_REUSE_EN
    reuse_tb = reuse;
`else
    if (reuse) $display("reuse requested without feature");
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (done_total != d0) begin got = 1; break; end
      if (poke && i == 4) begin
        // Ignored start with new bases mid-transfer
        start = 1'b1;
        tb_base = 16'($urandom); sw_base = 16'($urandom); sw_stride = 16'($urandom);
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("done_timeout", 32'(got), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_total - d0, 1);
  endtask

  task automatic basic_literals();
    chk("first_rd_cycle", first_rd, 1);
    chk("last_rd_cycle", last_rd, 80);
    chk("read_count", tr_rd, 80);
    chk("first_addr", rd_log[0], 16'h010F);
    chk("addr_cycle16", rd_log[15], 16'h0100);
    chk("addr_cycle17", rd_log[16], 16'h0200);
    chk("first_en_tb", first_tb, 3);
    chk("last_en_tb", last_tbc, 18);
    chk("en_tb_count", tr_tb, 16);
    chk("first_pel_tb", first_pel_tb, 8'h0F);
    chk("last_pel_tb", last_pel_tb, 8'h00);
    chk("first_en_sw", first_sw, 19);
    chk("last_en_sw", last_swc, 82);
    chk("en_sw_count", tr_sw, 64);
    chk("first_pel_sw", first_pel_sw, 8'h00);
    chk("last_pel_sw", last_pel_sw, 8'h3F);
    chk("done_cycle", done_rel, 83);
    chk("busy_first", busy_first, 1);
    chk("busy_last", busy_last, 83);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0;
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    tb_base = '0; sw_base = '0; sw_stride = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_read", rd_total, 0);
    chk("idle_busy", busy, 0);

    // Basic transfer with an ignored mid-transfer start
    run_transfer(16'h0100, 16'h0200, 16'd8, 1'b0, 1'b1);
    basic_literals();

    // Stride and address wrap
    run_transfer(16'h0040, 16'hFFF0, 16'd32, 1'b0, 1'b0);
    chk("wrap_row0", sw_log[0], 16'hFFF0);
    chk("wrap_row1", sw_log[8], 16'h0010);
    chk("wrap_row7", sw_log[56], 16'h00D0);
    chk("wrap_last", sw_log[63], 16'h00D7);

    // Stall storm
    stall_mode = 1;
    run_transfer(16'($urandom), 16'($urandom), 16'($urandom_range(8, 300)), 1'b0, 1'b1);
    chk("storm_en_tb", tr_tb, 16);
    chk("storm_en_sw", tr_sw, 64);
    stall_mode = 0;

    // Reset mid-operation at cycle 40
    tb_base = 16'h0100; sw_base = 16'h0200; sw_stride = 16'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    e0 = en_total; r0 = rd_total;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_en", en_total - e0, 0);
    chk("post_rst_no_rd", rd_total - r0, 0);
    stall_mode = 1;
    run_transfer(16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    chk("after_rst_en_tb", tr_tb, 16);
    chk("after_rst_en_sw", tr_sw, 64);
    stall_mode = 0;

`ifdef PEL_FEEDER_TB_REUSE_EN
    run_transfer(16'h0100, 16'h0200, 16'd8, 1'b1, 1'b0);
    chk("reuse_first_addr", rd_log[0], 16'h0200);
    chk("reuse_first_rd", first_rd, 1);
    chk("reuse_en_tb", tr_tb, 0);
    chk("reuse_done", done_rel, 67);
    run_transfer(16'h0100, 16'h0200, 16'd8, 1'b0, 1'b0);
    basic_literals();
`endif

    // Randomized transfers
    for (int n = 0; n < 4; n++) begin
      stall_mode = n % 2;
      run_transfer(16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      chk("rand_en_tb", tr_tb, 16);
      chk("rand_en_sw", tr_sw, 64);
    end
    stall_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pel_feeder.md
Name: pel_feeder

Overview:
- Streams template-block (TB) and search-window (SW) pixels from a pixel memory into the systolic PE array.
- Drives the pel_tb/en_tb and pel_sw/en_sw inputs of the first PE line; the array's shift chain carries them onward.
- Producer side of the PE-line pixel interface: issues memory reads, absorbs the fixed 1-cycle read latency, honours a downstream stall, and signals completion to the ME controller.

Parameters:
- ARRAY_SIZE, 16, PE array dimension; the TB is ARRAY_SIZE x ARRAY_SIZE pixels.
- SW_SIZE, 24, SW dimension, SW_SIZE x SW_SIZE pixels (ARRAY_SIZE + 2*4 for +/-4 search).
- ADDR_W, 16, pixel-memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one TB+SW transfer; sampled only in IDLE
- tb_base  in  ADDR_W  TB base address; TB stored contiguously, raster order
- sw_base  in  ADDR_W  SW base address
- sw_stride  in  ADDR_W  memory row pitch of the SW
- stall  in  1  downstream hold; while 1, no en_tb/en_sw pulse
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en
- pel_tb  out  8  TB pixel to PE line
- en_tb  out  1  TB shift enable, one pulse per pixel
- pel_sw  out  8  SW pixel to PE line
- en_sw  out  1  SW shift enable, one pulse per pixel
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset: all outputs 0, FSM to IDLE, all counters, the skid buffer and the in-flight flag cleared. rst mid-transfer aborts immediately; nothing is emitted after it.
- FSM states:
  - IDLE: start=1 goes to TB_RD.
  - TB_RD: issues ARRAY_SIZE^2 reads, then goes to SW_RD.
  - SW_RD: issues SW_SIZE^2 reads, then goes to DRAIN.
  - DRAIN: waits until the in-flight read, the skid buffer and the output register are empty, then pulses done and returns to IDLE.
- start while busy is ignored.
- tb_base, sw_base and sw_stride are latched on accepted start; later changes have no effect on the transfer.
- TB order: index k from ARRAY_SIZE^2-1 down to 0, mem_addr = tb_base + k. The last-pushed pixel, (0,0), ends at PE0 of line 0.
- SW order: row r = 0..SW_SIZE-1, col c = 0..SW_SIZE-1, mem_addr = sw_base + r*sw_stride + c.
- Address arithmetic is modulo 2^ADDR_W; wrap is allowed and not flagged.
- Read issue: a read issues in cycle t iff the state is TB_RD or SW_RD and stall=0. Each read carries a kind tag (TB or SW).
- Output register: data returning in t+1 loads the output register if stall=0 in t+1. Otherwise it goes to a 1-entry skid buffer.
- Skid buffer drains into the output register on the first cycle with stall=0, before any newer data. Depth 1 suffices because no read issues while stall=1.
- Output pulse: a loaded output register drives en_tb or en_sw (per tag) high for exactly one cycle, with pel_* valid in that cycle. Unstalled latency from read issue to en pulse is 2 cycles.
- en_tb and en_sw are never high together. Every TB pixel precedes every SW pixel.
- pel_tb and pel_sw hold their last value while their enable is 0.
- busy: 1 from the cycle after start is accepted through the done cycle inclusive.
- done: one-cycle pulse in the cycle after the final en_sw pulse.
- Stall: every pixel is emitted exactly once in order, with no loss or duplication, for any stall pattern, including stall asserted on the first or last pixel.

Optional Feature:
- Macro: PEL_FEEDER_TB_REUSE_EN.
- When defined:
  - Adds input port reuse_tb (1 bit), sampled with start.
  - reuse_tb=1 skips TB_RD entirely (IDLE goes to SW_RD), for consecutive searches with the same template. No en_tb pulses are produced and no TB reads are issued.
  - reuse_tb=0 gives normal behaviour.
- When undefined: the port does not exist and TB_RD always runs.

Test Plan (ARRAY_SIZE=4, SW_SIZE=8, memory model returns data = addr[7:0]):
- Reset, idle: hold rst 3 cycles, stall=0 -> all outputs 0; mem_rd_en stays 0 with start=0.
- Basic transfer: start at cycle 0, tb_base=0x100, sw_base=0x200, sw_stride=8, no stall.
  - mem_rd_en cycles 1..80; first addr 0x10F; addr 0x100 at cycle 16; addr 0x200 at cycle 17.
  - en_tb cycles 3..18 with pel_tb 0x0F down to 0x00.
  - en_sw cycles 19..82 with pel_sw 0x00..0x3F.
  - done at cycle 83; busy cycles 1..83.
- Stride/wrap: sw_stride=32, sw_base=0xFFF0 (ADDR_W=16) -> row1 addr 0x0010, row7 addr 0x00D0; pel_sw matches addr[7:0].
- Stall storm: pseudo-random stall at 50%, plus stall held 10 cycles over the TB/SW boundary -> exactly 16 en_tb then 64 en_sw, correct order, no duplicates, done once.
- Reset mid-op: rst at cycle 40 -> next cycle all outputs 0, no further en_*; a new start then yields a full correct transfer.
- PEL_FEEDER_TB_REUSE_EN defined:
  - start with reuse_tb=1 -> first read addr = sw_base at cycle 1, zero en_tb, done at cycle 67.
  - reuse_tb=0 -> identical to the basic-transfer case.
